// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels for two requesters plus
// the shared ALU operand/result bus and busy flag.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_rs1;
  logic [XLEN-1:0] req0_rs2;
  logic [2:0]      req0_ctrl;
  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_rs1;
  logic [XLEN-1:0] req1_rs2;
  logic [2:0]      req1_ctrl;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_rd;
  logic            rsp0_z;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_rd;
  logic            rsp1_z;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_rd;
  logic            alu_z;
  logic            busy;

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_ctrl,
    input  req1_valid, req1_rs1, req1_rs2, req1_ctrl,
    input  rsp0_ready, rsp1_ready, alu_rd, alu_z,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rd, rsp0_z,
    output rsp1_valid, rsp1_rd, rsp1_z,
    output alu_rs1, alu_rs2, alu_ctrl, busy
  );

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_ctrl,
    output req1_valid, req1_rs1, req1_rs2, req1_ctrl,
    output rsp0_ready, rsp1_ready, alu_rd, alu_z,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rd, rsp0_z,
    input  rsp1_valid, rsp1_rd, rsp1_z,
    input  alu_rs1, alu_rs2, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, round-robin grant.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [1:0]      rv_q, rv_d;
  logic [1:0]      z_q, z_d;
  logic [XLEN-1:0] rd0_q, rd0_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            rr_q, rr_d;
`endif

  logic v0, v1, gnt0, gnt1, idle, own_rdy;

  assign v0 = bus.req0_valid;
  assign v1 = bus.req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt0 = v0;
  assign gnt1 = v1 && !v0;
`else
  // rr_q names the requester favoured on a tie
  assign gnt0 = v0 && (!v1 || !rr_q);
  assign gnt1 = v1 && (!v0 || rr_q);
`endif

  // ready is forced low while reset is asserted
  assign idle    = rst_n && (state_q == IDLE);
  assign own_rdy = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    ctrl_d  = ctrl_q;
    rv_d    = rv_q;
    z_d     = z_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          rs1_d   = gnt1 ? bus.req1_rs1 : bus.req0_rs1;
          rs2_d   = gnt1 ? bus.req1_rs2 : bus.req0_rs2;
          ctrl_d  = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          if (owner_q) begin
            rd1_d   = bus.alu_rd;
            z_d[1]  = bus.alu_z;
            rv_d[1] = 1'b1;
          end else begin
            rd0_d   = bus.alu_rd;
            z_d[0]  = bus.alu_z;
            rv_d[0] = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (own_rdy) begin
          rv_d    = 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
          rr_d    = !owner_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      ctrl_q  <= '0;
      rv_q    <= '0;
      z_q     <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      ctrl_q  <= ctrl_d;
      rv_q    <= rv_d;
      z_q     <= z_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign bus.req0_ready = idle && gnt0;
  assign bus.req1_ready = idle && gnt1;
  assign bus.rsp0_valid = rv_q[0];
  assign bus.rsp1_valid = rv_q[1];
  assign bus.rsp0_rd    = rd0_q;
  assign bus.rsp1_rd    = rd1_q;
  assign bus.rsp0_z     = z_q[0];
  assign bus.rsp1_z     = z_q[1];
  assign bus.alu_rs1    = rs1_q;
  assign bus.alu_rs2    = rs2_q;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
